// File: rtl/iq_frame_fifo.sv
// iq_frame_fifo: frame-granular elastic buffer between the I/Q frame packer and the DMA.
// Only complete frames of exactly FRAME_WORDS beats are released downstream. Frames arriving
// while full are dropped whole; short and long frames are discarded, with the write side
// resynchronising on tlast.
// Optional build macro IQ_FRAME_FIFO_STATS_EN enables the frames_dropped / frame_errors
// counters; without it both outputs read 0.
module iq_frame_fifo #(
  parameter int unsigned FRAME_WORDS  = 8,
  parameter int unsigned DEPTH_FRAMES = 16,
  parameter int unsigned FL_W         = $clog2(DEPTH_FRAMES) + 1
) (
  input  logic            axis_aclk,
  input  logic            axis_reset,
  input  logic [31:0]     s00_axis_tdata,
  input  logic            s00_axis_tvalid,
  input  logic            s00_axis_tlast,
  output logic            s00_axis_tready,
  output logic [31:0]     m00_axis_tdata,
  output logic            m00_axis_tvalid,
  output logic            m00_axis_tlast,
  input  logic            m00_axis_tready,
  output logic [FL_W-1:0] fill_frames,
  output logic [15:0]     frames_dropped,
  output logic [15:0]     frame_errors
);

  localparam int unsigned SlotW = $clog2(DEPTH_FRAMES);
  localparam int unsigned WiW   = $clog2(FRAME_WORDS);
  localparam int unsigned AddrW = SlotW + WiW;
  localparam logic [WiW-1:0] LastWi = WiW'(FRAME_WORDS - 1);
  localparam logic [FL_W:0]  FullOcc = (FL_W + 1)'(DEPTH_FRAMES);

  typedef enum logic [1:0] {WrAccept, WrDrop, WrResync} wr_state_e;
  typedef enum logic {RdIdle, RdStream} rd_state_e;

  // Frame store, addressed as {slot, word index}
  logic [31:0] mem [2**AddrW];

  wr_state_e        wr_state_q, wr_state_d;
  logic [WiW-1:0]   wi_q, wi_d;
  logic [SlotW-1:0] wr_slot_q, wr_slot_d;
  logic             tready_q;
  logic             commit, commit_q;
  logic             mem_we;
  logic             drop_evt, err_evt;

  rd_state_e        rd_state_q, rd_state_d;
  logic [WiW-1:0]   rd_wi_q, rd_wi_d;
  logic [SlotW-1:0] rd_slot_q, rd_slot_d;
  logic [AddrW-1:0] rd_addr;
  logic             load, release_frame;
  logic [31:0]      m_data_q;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;

  logic [FL_W-1:0]  count_q, count_d;
  logic [FL_W:0]    occupancy;
  logic             beat;

  assign beat = s00_axis_tvalid & tready_q;
  // A commit still in the pipeline already owns its slot, so it counts towards fullness
  assign occupancy = {1'b0, count_q} + {{FL_W{1'b0}}, commit_q};

  // Write side: place beats into the current slot, commit or discard on frame boundaries
  always_comb begin
    wr_state_d = wr_state_q;
    wi_d       = wi_q;
    wr_slot_d  = wr_slot_q;
    mem_we     = 1'b0;
    commit     = 1'b0;
    drop_evt   = 1'b0;
    err_evt    = 1'b0;
    if (beat) begin
      unique case (wr_state_q)
        WrAccept: begin
          if (wi_q == '0 && occupancy >= FullOcc) begin
            if (s00_axis_tlast) drop_evt = 1'b1;
            else                wr_state_d = WrDrop;
          end else begin
            mem_we = 1'b1;
            if (s00_axis_tlast) begin
              wi_d = '0;
              if (wi_q == LastWi) begin
                commit    = 1'b1;
                wr_slot_d = wr_slot_q + 1'b1;
              end else begin
                err_evt = 1'b1;
              end
            end else if (wi_q == LastWi) begin
              err_evt    = 1'b1;
              wi_d       = '0;
              wr_state_d = WrResync;
            end else begin
              wi_d = wi_q + 1'b1;
            end
          end
        end
        WrDrop: begin
          if (s00_axis_tlast) begin
            drop_evt   = 1'b1;
            wr_state_d = WrAccept;
          end
        end
        WrResync: begin
          if (s00_axis_tlast) wr_state_d = WrAccept;
        end
        default: wr_state_d = WrAccept;
      endcase
    end
  end

  // Read side: fetch words of the oldest committed frame; chain frames without a bubble
  always_comb begin
    rd_state_d    = rd_state_q;
    rd_slot_d     = rd_slot_q;
    rd_wi_d       = rd_wi_q;
    rd_addr       = {rd_slot_q, rd_wi_q};
    load          = 1'b0;
    release_frame = 1'b0;
    m_valid_d     = m_valid_q;
    m_last_d      = m_last_q;
    unique case (rd_state_q)
      RdIdle: begin
        if (count_q != '0) begin
          load       = 1'b1;
          rd_addr    = {rd_slot_q, {WiW{1'b0}}};
          rd_wi_d    = WiW'(1);
          m_valid_d  = 1'b1;
          m_last_d   = 1'b0;
          rd_state_d = RdStream;
        end
      end
      RdStream: begin
        if (m00_axis_tready) begin
          if (m_last_q) begin
            release_frame = 1'b1;
            rd_slot_d     = rd_slot_q + 1'b1;
            if (count_q > FL_W'(1)) begin
              load      = 1'b1;
              rd_addr   = {rd_slot_d, {WiW{1'b0}}};
              rd_wi_d   = WiW'(1);
              m_valid_d = 1'b1;
              m_last_d  = 1'b0;
            end else begin
              m_valid_d  = 1'b0;
              m_last_d   = 1'b0;
              rd_state_d = RdIdle;
            end
          end else begin
            load     = 1'b1;
            rd_addr  = {rd_slot_q, rd_wi_q};
            m_last_d = (rd_wi_q == LastWi);
            rd_wi_d  = rd_wi_q + 1'b1;
          end
        end
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  // Committed frame count: a commit and a release in one cycle cancel
  always_comb begin
    count_d = count_q;
    if (commit_q && !release_frame)      count_d = count_q + 1'b1;
    else if (!commit_q && release_frame) count_d = count_q - 1'b1;
  end

  // Frame store write port (no reset on storage)
  always_ff @(posedge axis_aclk) begin
    if (mem_we) mem[{wr_slot_q, wi_q}] <= s00_axis_tdata;
  end

  // State registers, registered read port and output stage
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      wr_state_q <= WrAccept;
      wi_q       <= '0;
      wr_slot_q  <= '0;
      tready_q   <= 1'b0;
      commit_q   <= 1'b0;
      rd_state_q <= RdIdle;
      rd_wi_q    <= '0;
      rd_slot_q  <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wi_q       <= wi_d;
      wr_slot_q  <= wr_slot_d;
      tready_q   <= 1'b1;
      commit_q   <= commit;
      rd_state_q <= rd_state_d;
      rd_wi_q    <= rd_wi_d;
      rd_slot_q  <= rd_slot_d;
      if (load) m_data_q <= mem[rd_addr];
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      count_q    <= count_d;
    end
  end

  assign s00_axis_tready = tready_q;
  assign m00_axis_tdata  = m_data_q;
  assign m00_axis_tvalid = m_valid_q;
  assign m00_axis_tlast  = m_last_q;
  assign fill_frames     = count_q;

`ifdef IQ_FRAME_FIFO_STATS_EN
  logic [15:0] dropped_q, dropped_d;
  logic [15:0] errors_q, errors_d;

  // Saturating event counters
  always_comb begin
    dropped_d = dropped_q;
    errors_d  = errors_q;
    if (drop_evt && dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
    if (err_evt && errors_q != 16'hFFFF)   errors_d  = errors_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      dropped_q <= '0;
      errors_q  <= '0;
    end else begin
      dropped_q <= dropped_d;
      errors_q  <= errors_d;
    end
  end

  assign frames_dropped = dropped_q;
  assign frame_errors   = errors_q;
`else
  logic unused_stats;
  assign unused_stats   = drop_evt ^ err_evt;
  assign frames_dropped = '0;
  assign frame_errors   = '0;
`endif

endmodule

// File: tb/tb_iq_frame_fifo.sv
// tb_iq_frame_fifo: directed bench for iq_frame_fifo with default parameters (8 words, 16 frames).
module tb_iq_frame_fifo;

`ifdef IQ_FRAME_FIFO_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        axis_reset;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tlast, s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast, m_tready;
  logic [4:0]  fill;
  logic [15:0] dropped, errors;

  int n_cmp = 0;
  int n_err = 0;

  logic [32:0] got[$];
  logic [32:0] exp_q[$];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  always #5 clk = ~clk;

  iq_frame_fifo dut (
    .axis_aclk       (clk),
    .axis_reset      (axis_reset),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tready (s_tready),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tready (m_tready),
    .fill_frames     (fill),
    .frames_dropped  (dropped),
    .frame_errors    (errors)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Output monitor: collects accepted words and checks stability across stalls
  always @(negedge clk) begin
    if (axis_reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(m_tvalid), 64'd1);
        chk("stall_data", 64'(m_tdata), 64'(prev_data));
        chk("stall_last", 64'(m_tlast), 64'(prev_last));
      end
      if (m_tvalid && m_tready) got.push_back({m_tlast, m_tdata});
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends len beats base, base+1, ...; tlast on beat last_at. keep queues it as expected output.
  task automatic send_frame(input logic [31:0] base, input int len, input int last_at,
                            input bit keep);
    for (int i = 0; i < len; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = base + 32'(i);
      s_tlast  = (i == last_at);
      if (keep) exp_q.push_back({(i == 7), base + 32'(i)});
      step();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int c = 0; c < 4000 && got.size() < n; c++) step();
    repeat (12) step();
  endtask

  task automatic cmp_frames(input string tag);
    chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(tag, 64'(got[i]), 64'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_tready"}, 64'(s_tready), 64'd0);
    chk({tag, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, "_m_tlast"}, 64'(m_tlast), 64'd0);
    chk({tag, "_m_tdata"}, 64'(m_tdata), 64'd0);
    chk({tag, "_fill"}, 64'(fill), 64'd0);
    chk({tag, "_dropped"}, 64'(dropped), 64'd0);
    chk({tag, "_errors"}, 64'(errors), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    axis_reset = 1'b1;
    s_tdata    = '0;
    s_tvalid   = 1'b0;
    s_tlast    = 1'b0;
    m_tready   = 1'b0;

    // Reset values
    step();
    step();
    chk_reset_outputs("reset");
    axis_reset = 1'b0;
    step();
    chk("tready_rise", 64'(s_tready), 64'd1);

    // Single frame latency: fill +1 after N+1, word 0 after N+2
    m_tready = 1'b1;
    send_frame(32'h1, 8, 7, 1'b1);
    chk("lat_fill_n", 64'(fill), 64'd0);
    step();
    chk("lat_fill_n1", 64'(fill), 64'd1);
    chk("lat_valid_n1", 64'(m_tvalid), 64'd0);
    step();
    chk("lat_valid_n2", 64'(m_tvalid), 64'd1);
    chk("lat_data_n2", 64'(m_tdata), 64'h1);
    drain(8);
    cmp_frames("single");
    chk("single_fill_end", 64'(fill), 64'd0);
    chk("single_valid_end", 64'(m_tvalid), 64'd0);

    // Full buffer: 17 back-to-back frames with the DMA stalled
    m_tready = 1'b0;
    for (int f = 1; f <= 17; f++) send_frame(32'(f * 256 + 1), 8, 7, f <= 16);
    repeat (3) step();
    chk("full_fill", 64'(fill), 64'd16);
    chk("full_dropped", 64'(dropped), StatsEn ? 64'd1 : 64'd0);
    chk("full_head_valid", 64'(m_tvalid), 64'd1);
    chk("full_head_data", 64'(m_tdata), 64'h101);
    m_tready = 1'b1;
    drain(128);
    cmp_frames("full");
    chk("full_fill_end", 64'(fill), 64'd0);

    // Short frame then good frame
    send_frame(32'hA1, 5, 4, 1'b0);
    send_frame(32'hB1, 8, 7, 1'b1);
    drain(8);
    cmp_frames("short");
    chk("short_errors", 64'(errors), StatsEn ? 64'd1 : 64'd0);

    // Long frame then good frame
    send_frame(32'hC1, 10, 9, 1'b0);
    send_frame(32'hD1, 8, 7, 1'b1);
    drain(8);
    cmp_frames("long");
    chk("long_errors", 64'(errors), StatsEn ? 64'd2 : 64'd0);
    chk("long_fill", 64'(fill), 64'd0);

    // 100 random frames against a 50% ready DMA
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 100; f++) begin
          send_frame($urandom, 8, 7, 1'b1);
          repeat (16) step();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          m_tready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    m_tready = 1'b1;
    drain(800);
    cmp_frames("random");
    chk("random_dropped", 64'(dropped), StatsEn ? 64'd1 : 64'd0);

    // Reset with three frames buffered
    m_tready = 1'b0;
    for (int f = 0; f < 3; f++) send_frame(32'(32'hE000 + f * 16), 8, 7, 1'b0);
    repeat (3) step();
    chk("pre_reset_fill", 64'(fill), 64'd3);
    chk("pre_reset_valid", 64'(m_tvalid), 64'd1);
    axis_reset = 1'b1;
    step();
    chk_reset_outputs("midreset");
    axis_reset = 1'b0;
    step();
    chk("post_reset_tready", 64'(s_tready), 64'd1);
    m_tready = 1'b1;
    repeat (20) step();
    chk("post_reset_no_output", 64'(got.size()), 64'd0);
    send_frame(32'hF1, 8, 7, 1'b1);
    drain(8);
    cmp_frames("post_reset");
    chk("post_reset_fill", 64'(fill), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
